// File: rtl/fp16_accum_seq.sv
// Sequencing front-end for a registered binary16 adder: feeds running sum and operand, captures
// the sum back, and presents the total with an element count. Optional: FP_ACC_NAN_STICKY_EN.
`timescale 1ns/1ps

module fp16_accum_seq #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_data,
  input  logic             op_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_nan
);

  localparam int unsigned LatW = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              last_q, last_d;
  logic              skip_issue;

`ifdef FP_ACC_NAN_STICKY_EN
  logic nan_q, nan_d;
  logic sum_is_nan;
  assign sum_is_nan = (&add_sum[14:10]) && (|add_sum[9:0]);
  // Once the sum is NaN further adds cannot change it, so operands are only counted.
  assign skip_issue = nan_q;
  assign res_nan    = nan_q;
`else
  assign skip_issue = 1'b0;
  assign res_nan    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    last_d  = last_q;
`ifdef FP_ACC_NAN_STICKY_EN
    nan_d   = nan_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          last_d = op_last;
          cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          if (skip_issue) begin
            state_d = op_last ? StDone : StIdle;
          end else begin
            a_d     = acc_q;
            b_d     = op_data;
            lat_d   = LatW'(ADD_LAT);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          acc_d   = add_sum;
`ifdef FP_ACC_NAN_STICKY_EN
          if (sum_is_nan) nan_d = 1'b1;
`endif
          state_d = last_q ? StDone : StIdle;
        end
      end
      StDone: begin
        if (res_ready) begin
          acc_d   = 16'h0000;
          cnt_d   = '0;
`ifdef FP_ACC_NAN_STICKY_EN
          nan_d   = 1'b0;
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= StIdle;
      acc_q   <= 16'h0000;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      cnt_q   <= '0;
      lat_q   <= '0;
      last_q  <= 1'b0;
`ifdef FP_ACC_NAN_STICKY_EN
      nan_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
`ifdef FP_ACC_NAN_STICKY_EN
      nan_q   <= nan_d;
`endif
    end
  end

  assign op_ready  = (state_q == StIdle);
  assign res_valid = (state_q == StDone);
  assign res_data  = acc_q;
  assign res_count = cnt_q;
  assign add_a     = a_q;
  assign add_b     = b_q;

endmodule

// File: tb/tb_fp16_accum_seq.sv
// Directed bench for fp16_accum_seq with a one-stage adder model; a CNT_W=2 twin shares stimulus.
`timescale 1ns/1ps

module tb_fp16_accum_seq;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        op_valid, op_last, res_ready;
  logic [15:0] op_data;

  logic        op_ready, res_valid, res_nan;
  logic [15:0] add_a, add_b, add_sum, res_data;
  logic [7:0]  res_count;

  logic        op_ready2, res_valid2, res_nan2;
  logic [15:0] add_a2, add_b2, add_sum2, res_data2;
  logic [1:0]  res_count2;

  int checks = 0;
  int errors = 0;
  logic saw_b4000;

  always #5 CLK = ~CLK;

  fp16_accum_seq #(.ADD_LAT(1), .CNT_W(8)) u_dut (
    .CLK(CLK), .RESETn(RESETn), .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .op_last(op_last), .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_count(res_count), .res_nan(res_nan)
  );

  fp16_accum_seq #(.ADD_LAT(1), .CNT_W(2)) u_dut2 (
    .CLK(CLK), .RESETn(RESETn), .op_valid(op_valid), .op_ready(op_ready2), .op_data(op_data),
    .op_last(op_last), .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
    .res_count(res_count2), .res_nan(res_nan2)
  );

  function automatic logic is_nan(input logic [15:0] x);
    return (&x[14:10]) && (|x[9:0]);
  endfunction

  // Just enough of a binary16 adder for the directed vectors used here.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (a[14:0] == 15'h0) return b;
    if (b[14:0] == 15'h0) return a;
    case ({a, b})
      32'h3C00_4000: return 16'h4200;
      32'h4200_4200: return 16'h4600;
      default:       return 16'hDEAD;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      add_sum  <= 16'h0000;
      add_sum2 <= 16'h0000;
    end else begin
      add_sum  <= fp_add(add_a, add_b);
      add_sum2 <= fp_add(add_a2, add_b2);
    end
  end

  always @(posedge CLK) if (add_b == 16'h4000) saw_b4000 = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    while (!op_ready && n < 50) begin
      step();
      n++;
    end
    check("send_ready_timeout", {31'b0, op_ready}, 32'd1);
    op_valid = 1'b1;
    op_data  = d;
    op_last  = l;
    step();
    op_valid = 1'b0;
  endtask

  task automatic send_timed(input logic [15:0] d, input logic l);
    send(d, l);
    check("rdy_lo_t0", {31'b0, op_ready}, 32'd0);
    check("issue_b", {16'b0, add_b}, {16'b0, d});
    step();
    check("rdy_lo_t1", {31'b0, op_ready}, 32'd0);
    check("rv_lo_t1", {31'b0, res_valid}, 32'd0);
    step();
    if (l) check("rv_hi_t2", {31'b0, res_valid}, 32'd1);
    else   check("rdy_hi_t2", {31'b0, op_ready}, 32'd1);
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    check("res_timeout", {31'b0, res_valid}, 32'd1);
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, {31'b0, op_ready}, 32'd1);
    check({tag, "_rv"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_nan"}, {31'b0, res_nan}, 32'd0);
    check({tag, "_data"}, {16'b0, res_data}, 32'h0);
    check({tag, "_cnt"}, {24'b0, res_count}, 32'd0);
    check({tag, "_a"}, {16'b0, add_a}, 32'h0);
    check({tag, "_b"}, {16'b0, add_b}, 32'h0);
  endtask

  initial begin
    RESETn = 1'b0; op_valid = 1'b0; op_last = 1'b0; op_data = 16'h0; res_ready = 1'b0;
    saw_b4000 = 1'b0;
    repeat (3) step();
    check_reset_vals("rst");
    RESETn = 1'b1;
    step();

    // Single operand
    send_timed(16'h3C00, 1'b1);
    check("single_data", {16'b0, res_data}, 32'h3C00);
    check("single_cnt", {24'b0, res_count}, 32'd1);
    take_res();

    // Three-operand stream
    send_timed(16'h3C00, 1'b0);
    send_timed(16'h4000, 1'b0);
    send_timed(16'h4200, 1'b1);
    check("stream_data", {16'b0, res_data}, 32'h4600);
    check("stream_cnt", {24'b0, res_count}, 32'd3);

    // Back-pressure in DONE with a pending operand
    op_valid = 1'b1; op_data = 16'h3C00; op_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_rv", {31'b0, res_valid}, 32'd1);
      check("hold_data", {16'b0, res_data}, 32'h4600);
      check("hold_cnt", {24'b0, res_count}, 32'd3);
      check("hold_rdy", {31'b0, op_ready}, 32'd0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("clr_rdy", {31'b0, op_ready}, 32'd1);
    check("clr_cnt", {24'b0, res_count}, 32'd0);
    check("clr_data", {16'b0, res_data}, 32'h0);
    step();
    op_valid = 1'b0;
    check("clr_accept", {31'b0, op_ready}, 32'd0);
    check("clr_a", {16'b0, add_a}, 32'h0);
    check("clr_b", {16'b0, add_b}, 32'h3C00);
    wait_res();
    check("clr_res_data", {16'b0, res_data}, 32'h3C00);
    check("clr_res_cnt", {24'b0, res_count}, 32'd1);
    take_res();

    // NaN in the stream
    saw_b4000 = 1'b0;
    send(16'h3C00, 1'b0);
    send(16'h7E00, 1'b0);
    send(16'h4000, 1'b1);
    wait_res();
    check("nan_data_isnan", {31'b0, is_nan(res_data)}, 32'd1);
    check("nan_cnt", {24'b0, res_count}, 32'd3);
`ifdef FP_ACC_NAN_STICKY_EN
    check("nan_flag", {31'b0, res_nan}, 32'd1);
    check("nan_no_issue", {31'b0, saw_b4000}, 32'd0);
`else
    check("nan_flag", {31'b0, res_nan}, 32'd0);
    check("nan_issued", {31'b0, saw_b4000}, 32'd1);
`endif
    take_res();
    check("nan_clear", {31'b0, res_nan}, 32'd0);

    // Reset in WAIT of the second operand
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    check("prerst_b", {16'b0, add_b}, 32'h4000);
    RESETn = 1'b0;
    #1;
    check_reset_vals("midrst");
    step();
    step();
    RESETn = 1'b1;
    step();
    send(16'h4000, 1'b1);
    wait_res();
    check("postrst_data", {16'b0, res_data}, 32'h4000);
    check("postrst_cnt", {24'b0, res_count}, 32'd1);
    take_res();

    // Count saturation on the CNT_W=2 twin
    for (int i = 0; i < 5; i++) send(16'h0000, (i == 4));
    wait_res();
    check("sat_cnt8", {24'b0, res_count}, 32'd5);
    check("sat_rv2", {31'b0, res_valid2}, 32'd1);
    check("sat_cnt2", {30'b0, res_count2}, 32'd3);
    check("sat_data2", {16'b0, res_data2}, 32'h0);
    take_res();
    check("sat_clr2", {30'b0, res_count2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_accum_seq.md
# fp16_accum_seq

Sequencing front-end for the half-precision adder. It accepts a stream of IEEE-754 binary16 operands over a valid/ready handshake and drives the adder's A/B inputs with the running sum and the next operand. It captures the adder's registered sum back into the accumulator and presents the final total, with an element count, on a second valid/ready handshake when the operand tagged last has been absorbed. It sits directly upstream of the adder and also consumes the adder's output.

## Interface
- ADD_LAT, 1: register stages inside the adder between A/B and sum (the current adder has 1).
- CNT_W, 8: width of the element counter.
- CLK  input  1  clock; all state updates on the rising edge.
- RESETn  input  1  asynchronous active-low reset; also wired to the adder.
- op_valid  input  1  operand present.
- op_ready  output  1  block can accept an operand.
- op_data  input  16  binary16 operand {sign, exp[4:0], frac[9:0]}.
- op_last  input  1  operand is the final element of this accumulation.
- add_a  output  16  to adder A (running sum).
- add_b  output  16  to adder B (operand).
- add_sum  input  16  registered sum from the adder.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer ready.
- res_data  output  16  accumulated binary16 total.
- res_count  output  CNT_W  number of operands absorbed, saturating.
- res_nan  output  1  running sum is NaN (see Configuration).

## Operation
- States:
  - IDLE: op_ready=1.
  - WAIT: op_ready=0; the latency counter runs.
  - DONE: res_valid=1, op_ready=0.
- Accumulator acc[15:0] starts at 16'h0000 (+0). The adder's zero-operand path returns B, so the first add yields the operand unchanged.
- IDLE:
  - On op_valid&op_ready, register add_a<=acc, add_b<=op_data and last_q<=op_last.
  - Increment the count, saturating at 2^CNT_W-1.
  - Load the latency counter with ADD_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle while it is nonzero.
  - In the cycle the counter is 0, capture acc<=add_sum.
  - Then go to DONE if last_q, else go to IDLE.
- DONE:
  - res_data=acc and res_count=count, both stable while res_valid=1.
  - On res_valid&res_ready: acc<=16'h0000, count<=0, go to IDLE.
- add_a and add_b hold their value outside the issue edge, so the adder input is stable for the full latency.
- No arithmetic is done in this block. Special values (NaN, Inf, zero) are resolved entirely by the adder. acc takes add_sum bit-for-bit.
- op_valid is ignored in WAIT and DONE. Upstream must hold op_data and op_last until the cycle in which op_ready is high.
- Count saturation: once the count reaches 2^CNT_W-1 it stays there; accumulation continues.

## Timing
- Reset values:
  - op_ready=1; res_valid=0; res_nan=0.
  - res_data=16'h0000; res_count=0; add_a=add_b=16'h0000.
  - State IDLE, acc=0, count=0, last_q=0.
- Per-operand cycle, for an operand accepted at edge t:
  - add_a and add_b are valid after t.
  - The adder registers its sum at t+ADD_LAT.
  - acc captures it at edge t+ADD_LAT+1.
  - op_ready rises again after t+ADD_LAT+1.
- Throughput is one operand per ADD_LAT+2 cycles; with ADD_LAT=1 that is 3 cycles.
- Result latency: res_valid rises the cycle after the capture edge of the last operand.
- Result clear: a handshake at edge u clears acc and count and returns the block to IDLE. op_ready is high after u, so the earliest next operand is accepted at edge u+1.
- Reset asserted mid-WAIT aborts the operation. The in-flight adder result is discarded, because the adder is reset on the same signal, and all outputs return to their reset values immediately.

## Configuration
- FP_ACC_NAN_STICKY_EN defined:
  - After each capture, if add_sum has exp=5'b11111 and frac!=0, set a sticky flag; res_nan shows the flag.
  - While the flag is set, accepted operands are counted but not issued. The block skips WAIT and acc holds the NaN; op_last still leads to DONE.
  - The flag clears on the result handshake and on reset.
- Not defined: res_nan is tied to 0 and every operand is issued to the adder (NaN still propagates through the adder's own handling).

## Test plan
- Reset release, then a single operand 16'h3C00 with op_last=1 -> res_valid three cycles after acceptance, res_data=16'h3C00, res_count=1.
- Stream 16'h3C00, 16'h4000, 16'h4200 (last) -> res_data=16'h4600 (6.0), res_count=3. Check op_ready low exactly 2 cycles after each acceptance.
- Hold res_ready=0 for 5 cycles in DONE with op_valid=1 -> res_data/res_count stable, no operand accepted. Raise res_ready -> acc cleared and next operand accepted one cycle later.
- Stream 16'h3C00, 16'h7E00 (NaN), 16'h4000 (last):
  - With FP_ACC_NAN_STICKY_EN: res_nan=1, res_data NaN, res_count=3, and the third operand is never issued (add_b never equals 16'h4000).
  - Without the macro: res_nan=0.
- Assert RESETn low in WAIT of the second operand -> all outputs at reset values immediately. A fresh stream of 16'h4000 (last) after release gives res_data=16'h4000, res_count=1.
- CNT_W=2 with 5 operands of 16'h0000 -> res_count=3 (saturated), res_data=16'h0000.
